health_manager: RTL and testbench
=================================

# health_manager

Sequential health/KO stage directly downstream of the combinational hit judge. Consumes the per-character `hurt` levels, converts each qualified hit into a fixed damage deduction with a frame-counted invulnerability window, tracks both health bars, and runs the round state machine (idle → fight → KO) that reports the winner to the HUD and game controller.

## Interface
Parameters:
- `HP_W`, 8: health register width
- `MAX_HP`, 100: health loaded at reset and round start (must fit `HP_W`)
- `DAMAGE`, 10: health removed per qualified hit
- `INVULN_FRAMES`, 30: frame ticks of invulnerability after a hit
- `REGEN_FRAMES`, 60: frame ticks per +1 HP regeneration (used only with `HEALTH_REGEN_EN`)

Ports:
- `Clk`  in  1  system clock; the only clock
- `Reset_n`  in  1  reset; asynchronous, active-low
- `frame_tick`  in  1  one-`Clk` strobe per video frame
- `round_start`  in  1  one-cycle strobe; starts or restarts a round
- `character1_hurt`, `character2_hurt`  in  1 each  hit-judge levels; may stay high for many cycles
- `health1`, `health2`  out  `HP_W` each  current health
- `hit_flash1`, `hit_flash2`  out  1 each  high while that character is invulnerable
- `ko`  out  1  high in KO state
- `winner`  out  2  00 none, 01 player 1, 10 player 2, 11 draw

## Operation
- States: IDLE, FIGHT, KO.
- Reset: IDLE; `health1`/`health2` = `MAX_HP`; invulnerability counters 0; `hit_flash*` = 0; `ko` = 0; `winner` = 00; regen counters 0.
- `round_start` is accepted in every state: next cycle is FIGHT, both healths = `MAX_HP`, invulnerability and regen counters = 0, `winner` = 00. It overrides any hit arriving in the same cycle.
- In IDLE and KO, `hurt` inputs are ignored and health does not change.
- In FIGHT, a qualified hit for character N is a cycle with `characterN_hurt` = 1 and invulnerability counter N = 0.
- Qualified hit: health N ← (health N ≤ `DAMAGE`) ? 0 : health N − `DAMAGE` (saturating, never wraps); counter N ← `INVULN_FRAMES`.
- Counter N decrements by 1 on each `frame_tick` while nonzero. A hit load wins over a same-cycle decrement.
- `hit_flash N` = (counter N ≠ 0), registered.
- Both characters are independent. Same-cycle hits on both both apply.
- FIGHT → KO when either registered health is 0. `winner`: only health2 = 0 → 01; only health1 = 0 → 10; both 0 → 11. `winner` holds until `round_start` or reset.
- KO persists until `round_start`. Invulnerability counters keep counting down in KO.

## Timing
- Hurt is sampled on edge k. Health and `hit_flash` update at edge k+1.
- If that hit zeroes health, `ko` and `winner` are valid from edge k+2.
- `round_start` at edge k: FIGHT state and `MAX_HP` are visible after edge k+1.
- Invulnerability lasts exactly `INVULN_FRAMES` `frame_tick` pulses after the hit cycle. Hurt is re-qualified in the first cycle the counter reads 0.
- `Reset_n` low mid-round clears all state immediately, without waiting for `Clk`.

## Configuration
- `HEALTH_REGEN_EN` defined:
  - In FIGHT only, each character has a frame counter. It advances only while that character is not invulnerable and health is below `MAX_HP`.
  - When the counter reaches `REGEN_FRAMES` ticks, health +1 (capped at `MAX_HP`) and the counter clears.
  - A qualified hit clears that character's counter.
  - Regeneration never applies to a character with health 0.
- Undefined: no regeneration logic and no regen counters. `REGEN_FRAMES` is unused.

## Structure
- `fight_pkg` holds:
  - the `round_state_t` enum (IDLE, FIGHT, KO)
  - the `winner_t` encodings (NONE, P1, P2, DRAW)
  - a default `HP_W` constant
- Sub-module `fighter_hp` is instantiated twice. It contains one character's health register, invulnerability counter, optional regen counter and hit qualification. Its inputs are `hurt`, `frame_tick`, an `enable` (state = FIGHT) and `reload`.
- The top level holds the round FSM and the winner logic.

## Test plan
- Reset: deassert `Reset_n` → health1 = health2 = 100, `ko` = 0, `winner` = 00, flashes 0. Hurt in IDLE → no change.
- `round_start`, then `character2_hurt` high for 1 cycle → health2 = 90 next cycle, `hit_flash2` = 1. After 30 `frame_tick`s → `hit_flash2` = 0.
- `character1_hurt` held high across 65 frame ticks (`INVULN_FRAMES` = 30) → health1 steps 100 → 90 → 80 → 70: one hit at the start and one each time the counter expires.
- Ten spaced hits on player 2 → health2 = 0 → `ko` = 1 and `winner` = 01 two cycles after the last hurt. Further hurts are ignored.
- Both at health 5, simultaneous hurts → both saturate to 0 (no wrap), `winner` = 11.
- `round_start` in KO → FIGHT, both healths 100, `winner` = 00. With `HEALTH_REGEN_EN`: a player at 90 not hit for 60 ticks → 91.

Source files
------------

// File: rtl/fight_pkg.sv
// Shared types for the fighting-game health stage: round states, winner codes
// and the default health register width.
package fight_pkg;

  localparam int HP_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    KO    = 2'd2
  } round_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DRAW = 2'b11
  } winner_t;

endpackage

// File: rtl/fighter_hp.sv
// One character's health bar: hit qualification, saturating damage and the
// frame-counted invulnerability window. Regeneration exists only with HEALTH_REGEN_EN.
module fighter_hp import fight_pkg::*; #(
  parameter int HP_W          = HP_W_DEFAULT,
  parameter int MAX_HP        = 100,
  parameter int DAMAGE        = 10,
  parameter int INVULN_FRAMES = 30,
  parameter int REGEN_FRAMES  = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_tick,
  input  logic            enable,
  input  logic            reload,
  input  logic            hurt,
  output logic [HP_W-1:0] health,
  output logic            hit_flash
);

  localparam int INV_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);

  logic [INV_W-1:0] invuln_cnt;
  logic [INV_W-1:0] invuln_next;
  logic             qualified;
  logic             regen_step;
  logic [HP_W-1:0]  hit_health;

  assign qualified  = enable && hurt && (invuln_cnt == '0);
  assign hit_health = (health <= HP_W'(DAMAGE)) ? '0 : health - HP_W'(DAMAGE);

  // A fresh hit reloads the window even if a frame tick lands in the same cycle.
  always_comb begin
    invuln_next = invuln_cnt;
    if (reload) begin
      invuln_next = '0;
    end else if (qualified) begin
      invuln_next = INV_W'(INVULN_FRAMES);
    end else if (frame_tick && (invuln_cnt != '0)) begin
      invuln_next = invuln_cnt - INV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invuln_cnt <= '0;
      hit_flash  <= 1'b0;
    end else begin
      invuln_cnt <= invuln_next;
      hit_flash  <= (invuln_next != '0);
    end
  end

`ifdef HEALTH_REGEN_EN
  localparam int RG_W = (REGEN_FRAMES < 2) ? 1 : $clog2(REGEN_FRAMES);

  logic [RG_W-1:0] regen_cnt;
  logic            regen_active;

  assign regen_active = enable && frame_tick && (invuln_cnt == '0) &&
                        (health != '0) && (health < HP_W'(MAX_HP));
  assign regen_step   = regen_active && (regen_cnt == RG_W'(REGEN_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regen_cnt <= '0;
    end else if (reload || qualified || regen_step) begin
      regen_cnt <= '0;
    end else if (regen_active) begin
      regen_cnt <= regen_cnt + RG_W'(1);
    end
  end
`else
  assign regen_step = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health <= HP_W'(MAX_HP);
    end else if (reload) begin
      health <= HP_W'(MAX_HP);
    end else if (qualified) begin
      health <= hit_health;
    end else if (regen_step) begin
      health <= health + HP_W'(1);
    end
  end

endmodule

// File: rtl/health_manager.sv
// Round controller (IDLE -> FIGHT -> KO) and winner reporting over two fighter_hp
// health bars. Optional regeneration is enabled by defining HEALTH_REGEN_EN.
module health_manager import fight_pkg::*; #(
  parameter int HP_W          = HP_W_DEFAULT,
  parameter int MAX_HP        = 100,
  parameter int DAMAGE        = 10,
  parameter int INVULN_FRAMES = 30,
  parameter int REGEN_FRAMES  = 60
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_tick,
  input  logic            round_start,
  input  logic            character1_hurt,
  input  logic            character2_hurt,
  output logic [HP_W-1:0] health1,
  output logic [HP_W-1:0] health2,
  output logic            hit_flash1,
  output logic            hit_flash2,
  output logic            ko,
  output logic [1:0]      winner
);

  round_state_t state, state_next;
  winner_t      win_q, win_next;
  logic         fighting;

  assign fighting = (state == FIGHT);

  fighter_hp #(
    .HP_W(HP_W), .MAX_HP(MAX_HP), .DAMAGE(DAMAGE),
    .INVULN_FRAMES(INVULN_FRAMES), .REGEN_FRAMES(REGEN_FRAMES)
  ) u_p1 (
    .clk(Clk), .rst_n(Reset_n), .frame_tick(frame_tick), .enable(fighting),
    .reload(round_start), .hurt(character1_hurt), .health(health1), .hit_flash(hit_flash1)
  );

  fighter_hp #(
    .HP_W(HP_W), .MAX_HP(MAX_HP), .DAMAGE(DAMAGE),
    .INVULN_FRAMES(INVULN_FRAMES), .REGEN_FRAMES(REGEN_FRAMES)
  ) u_p2 (
    .clk(Clk), .rst_n(Reset_n), .frame_tick(frame_tick), .enable(fighting),
    .reload(round_start), .hurt(character2_hurt), .health(health2), .hit_flash(hit_flash2)
  );

  // KO is judged on the registered health bars, one cycle after the fatal hit lands.
  always_comb begin
    state_next = state;
    win_next   = win_q;
    if (round_start) begin
      state_next = FIGHT;
      win_next   = NONE;
    end else if (fighting && ((health1 == '0) || (health2 == '0))) begin
      state_next = KO;
      if ((health1 == '0) && (health2 == '0)) begin
        win_next = DRAW;
      end else if (health2 == '0) begin
        win_next = P1;
      end else begin
        win_next = P2;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      win_q <= NONE;
    end else begin
      state <= state_next;
      win_q <= win_next;
    end
  end

  assign ko     = (state == KO);
  assign winner = win_q;

endmodule

// File: tb/tb_health_manager.sv
// Self-checking bench for health_manager: directed scenarios plus a randomized
// run against a behavioural model of the round rules (honours HEALTH_REGEN_EN).
module tb_health_manager;

  localparam int HPW    = 8;
  localparam int MAXHP  = 100;
  localparam int DMG    = 10;
  localparam int INV    = 30;
  localparam int REGEN  = 60;

  logic           Clk = 1'b0;
  logic           Reset_n = 1'b0;
  logic           frame_tick = 1'b0;
  logic           round_start = 1'b0;
  logic           character1_hurt = 1'b0;
  logic           character2_hurt = 1'b0;
  logic [HPW-1:0] health1, health2;
  logic           hit_flash1, hit_flash2, ko;
  logic [1:0]     winner;

  logic [HPW-1:0] b_health1, b_health2;
  logic           b_hit_flash1, b_hit_flash2, b_ko;
  logic [1:0]     b_winner;

  int checks = 0;
  int failures = 0;

  int m_hp[2];
  int m_inv[2];
  int m_rg[2];
  int m_round;
  int m_win;

  always #5 Clk = ~Clk;

  health_manager #(
    .HP_W(HPW), .MAX_HP(MAXHP), .DAMAGE(DMG), .INVULN_FRAMES(INV), .REGEN_FRAMES(REGEN)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .round_start(round_start),
    .character1_hurt(character1_hurt), .character2_hurt(character2_hurt),
    .health1(health1), .health2(health2), .hit_flash1(hit_flash1), .hit_flash2(hit_flash2),
    .ko(ko), .winner(winner)
  );

  health_manager #(
    .HP_W(HPW), .MAX_HP(95), .DAMAGE(DMG), .INVULN_FRAMES(2), .REGEN_FRAMES(REGEN)
  ) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .round_start(round_start),
    .character1_hurt(character1_hurt), .character2_hurt(character2_hurt),
    .health1(b_health1), .health2(b_health2), .hit_flash1(b_hit_flash1), .hit_flash2(b_hit_flash2),
    .ko(b_ko), .winner(b_winner)
  );

  task automatic cycle(input bit rs, input bit ft, input bit h1, input bit h2);
    @(negedge Clk);
    round_start     = rs;
    frame_tick      = ft;
    character1_hurt = h1;
    character2_hurt = h2;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (health1 !== 8'd100 || health2 !== 8'd100 || ko !== 1'b0 || winner !== 2'b00 ||
        hit_flash1 !== 1'b0 || hit_flash2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: h1=%0d h2=%0d ko=%b win=%b f1=%b f2=%b expected 100 100 0 00 0 0",
               health1, health2, ko, winner, hit_flash1, hit_flash2);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) cycle(0, 1, 1, 1);
    checks++;
    if (health1 !== 8'd100 || health2 !== 8'd100 || hit_flash1 !== 1'b0 || ko !== 1'b0) begin
      failures++;
      $display("FAIL idle_hurt_ignored: h1=%0d h2=%0d f1=%b ko=%b expected 100 100 0 0",
               health1, health2, hit_flash1, ko);
    end
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 1);
    checks++;
    if (health1 !== 8'd90 || health2 !== 8'd90) begin
      failures++;
      $display("FAIL both_hit: h1=%0d h2=%0d expected 90 90", health1, health2);
    end
    #3;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (health1 !== 8'd100 || health2 !== 8'd100 || hit_flash1 !== 1'b0 || hit_flash2 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: h1=%0d h2=%0d f1=%b f2=%b expected 100 100 0 0",
               health1, health2, hit_flash1, hit_flash2);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_single_hit();
    cycle(1, 0, 0, 0);
    checks++;
    if (health1 !== 8'd100 || health2 !== 8'd100 || ko !== 1'b0) begin
      failures++;
      $display("FAIL round_start: h1=%0d h2=%0d ko=%b expected 100 100 0", health1, health2, ko);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (health2 !== 8'd90 || hit_flash2 !== 1'b1 || health1 !== 8'd100 || hit_flash1 !== 1'b0) begin
      failures++;
      $display("FAIL single_hit: h2=%0d f2=%b h1=%0d f1=%b expected 90 1 100 0",
               health2, hit_flash2, health1, hit_flash1);
    end
    for (int i = 1; i <= INV; i++) begin
      cycle(0, 1, 0, 0);
      if (i == INV - 1) begin
        checks++;
        if (hit_flash2 !== 1'b1) begin
          failures++;
          $display("FAIL flash_29_ticks: f2=%b expected 1", hit_flash2);
        end
      end
    end
    checks++;
    if (hit_flash2 !== 1'b0 || health2 !== 8'd90) begin
      failures++;
      $display("FAIL flash_expired: f2=%b h2=%0d expected 0 90", hit_flash2, health2);
    end
  endtask

  task automatic test_held_hurt();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (health1 !== 8'd90) begin
      failures++;
      $display("FAIL held_first_hit: h1=%0d expected 90", health1);
    end
    for (int i = 1; i <= 65; i++) begin
      cycle(0, 1, 1, 0);
      cycle(0, 0, 1, 0);
      if (i == INV) begin
        checks++;
        if (health1 !== 8'd80) begin
          failures++;
          $display("FAIL held_second_hit: h1=%0d expected 80", health1);
        end
      end
    end
    checks++;
    if (health1 !== 8'd70 || hit_flash1 !== 1'b1 || health2 !== 8'd100) begin
      failures++;
      $display("FAIL held_final: h1=%0d f1=%b h2=%0d expected 70 1 100", health1, hit_flash1, health2);
    end
  endtask

  task automatic test_ko_p1_wins();
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0, 0, 1);
      checks++;
      if (health2 !== 8'(MAXHP - DMG * i)) begin
        failures++;
        $display("FAIL spaced_hit_%0d: h2=%0d expected %0d", i, health2, MAXHP - DMG * i);
      end
      if (i < 10) repeat (INV) cycle(0, 1, 0, 0);
    end
    checks++;
    if (ko !== 1'b0 || winner !== 2'b00) begin
      failures++;
      $display("FAIL ko_early: ko=%b win=%b expected 0 00", ko, winner);
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (ko !== 1'b1 || winner !== 2'b01) begin
      failures++;
      $display("FAIL ko_p1: ko=%b win=%b expected 1 01", ko, winner);
    end
    repeat (INV) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    checks++;
    if (health1 !== 8'd100 || health2 !== 8'd0 || ko !== 1'b1 || winner !== 2'b01) begin
      failures++;
      $display("FAIL ko_hurt_ignored: h1=%0d h2=%0d ko=%b win=%b expected 100 0 1 01",
               health1, health2, ko, winner);
    end
  endtask

  task automatic test_restart();
    cycle(1, 0, 0, 0);
    checks++;
    if (health1 !== 8'd100 || health2 !== 8'd100 || ko !== 1'b0 || winner !== 2'b00) begin
      failures++;
      $display("FAIL restart: h1=%0d h2=%0d ko=%b win=%b expected 100 100 0 00",
               health1, health2, ko, winner);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (health1 !== 8'd90) begin
      failures++;
      $display("FAIL restart_fight: h1=%0d expected 90", health1);
    end
`ifdef HEALTH_REGEN_EN
    repeat (INV + REGEN - 1) cycle(0, 1, 0, 0);
    checks++;
    if (health1 !== 8'd90) begin
      failures++;
      $display("FAIL regen_early: h1=%0d expected 90", health1);
    end
    cycle(0, 1, 0, 0);
    checks++;
    if (health1 !== 8'd91) begin
      failures++;
      $display("FAIL regen_step: h1=%0d expected 91", health1);
    end
`else
    repeat (INV + REGEN) cycle(0, 1, 0, 0);
    checks++;
    if (health1 !== 8'd90) begin
      failures++;
      $display("FAIL no_regen: h1=%0d expected 90", health1);
    end
`endif
  endtask

  task automatic test_draw_saturate();
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      cycle(0, 0, 1, 1);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
    end
    checks++;
    if (b_health1 !== 8'd5 || b_health2 !== 8'd5) begin
      failures++;
      $display("FAIL draw_setup: h1=%0d h2=%0d expected 5 5", b_health1, b_health2);
    end
    cycle(0, 0, 1, 1);
    checks++;
    if (b_health1 !== 8'd0 || b_health2 !== 8'd0 || b_ko !== 1'b0) begin
      failures++;
      $display("FAIL saturate: h1=%0d h2=%0d ko=%b expected 0 0 0", b_health1, b_health2, b_ko);
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (b_ko !== 1'b1 || b_winner !== 2'b11) begin
      failures++;
      $display("FAIL draw: ko=%b win=%b expected 1 11", b_ko, b_winner);
    end
  endtask

  // Behavioural view of one clock edge, written from the round rules.
  task automatic model_step(input bit rs, input bit ft, input bit h1, input bit h2);
    int  old_hp[2];
    bit  hurt[2];
    bit  in_fight;
    hurt[0]  = h1;
    hurt[1]  = h2;
    old_hp   = m_hp;
    in_fight = (m_round == 1);
    if (rs) begin
      for (int n = 0; n < 2; n++) begin
        m_hp[n] = MAXHP; m_inv[n] = 0; m_rg[n] = 0;
      end
      m_round = 1;
      m_win   = 0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (in_fight && hurt[n] && m_inv[n] == 0) begin
          m_hp[n]  = (m_hp[n] <= DMG) ? 0 : m_hp[n] - DMG;
          m_inv[n] = INV;
          m_rg[n]  = 0;
        end else begin
`ifdef HEALTH_REGEN_EN
          if (in_fight && ft && m_inv[n] == 0 && m_hp[n] > 0 && m_hp[n] < MAXHP) begin
            m_rg[n]++;
            if (m_rg[n] == REGEN) begin
              m_hp[n]++;
              m_rg[n] = 0;
            end
          end
`endif
          if (ft && m_inv[n] > 0) m_inv[n]--;
        end
      end
      if (in_fight && (old_hp[0] == 0 || old_hp[1] == 0)) begin
        m_round = 2;
        m_win   = (old_hp[1] == 0 ? 1 : 0) + (old_hp[0] == 0 ? 2 : 0);
      end
    end
  endtask

  task automatic test_random();
    bit rs, ft, h1, h2;
    logic [20:0] got, want;
    Reset_n = 1'b0;
    @(posedge Clk);
    for (int n = 0; n < 2; n++) begin
      m_hp[n] = MAXHP; m_inv[n] = 0; m_rg[n] = 0;
    end
    m_round = 0;
    m_win   = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    h1 = 1'b0;
    h2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rs = (i == 5) || ($urandom_range(0, 699) == 0);
      ft = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) h1 = ~h1;
      if ($urandom_range(0, 5) == 0) h2 = ~h2;
      cycle(rs, ft, h1, h2);
      model_step(rs, ft, h1, h2);
      want = {8'(m_hp[0]), 8'(m_hp[1]), m_inv[0] != 0, m_inv[1] != 0, m_round == 2, 2'(m_win)};
      got  = {health1, health2, hit_flash1, hit_flash2, ko, winner};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random_cycle_%0d: got h1=%0d h2=%0d f=%b%b ko=%b win=%b expected h1=%0d h2=%0d f=%b%b ko=%b win=%b",
                 i, got[20:13], got[12:5], got[4], got[3], got[2], got[1:0],
                 want[20:13], want[12:5], want[4], want[3], want[2], want[1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_held_hurt();
    test_ko_p1_wins();
    test_restart();
    test_draw_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
